pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Sequences the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Consumes the hazard unit's decisions (load-use hazard, taken branch, jump) and the cache handshakes (ihit, dhit).
- Drives per-latch enable/flush and PC enable.
- Owns multi-cycle load-use stall sequencing, data-miss freeze, halt latching and stall/flush performance counters.
- Sits beside the hazard unit in the datapath top level.

Parameters:
- LDSTALL_CYC, 1: bubbles inserted per load-use hazard (1..15).
- CNT_W, 32: width of the performance counters.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- hazard  in  1  load-use hazard detected in ID.
- branch  in  1  taken branch resolved in ID.
- jump  in  1  jump resolved in ID.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- mem_dREN  in  1  MEM-stage load request.
- mem_dWEN  in  1  MEM-stage store request.
- mem_halt  in  1  halt instruction in MEM.
- pc_en  out  1  PC load enable.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  synchronous latch clear (bubble).
- halt_out  out  1  registered halt, sticky.
- stall_cnt  out  CNT_W  load-use bubble count.
- flush_cnt  out  CNT_W  branch/jump flush count.
- state_o  out  2  current state (debug).

Behaviour:
- Single clock, one state register. Enables and flushes are combinational from the state and the current inputs. Counters, the state and halt_out are registered.
- Reset (async, RST=1):
  - state=RUN, ldcnt=0, halt_out=0, stall_cnt=0, flush_cnt=0.
  - While RST=1, all *_en=0, all *_flush=0 and pc_en=0 (forced).
- dmiss = (mem_dREN|mem_dWEN) & !dhit.
- States and priority (first match wins):
  - RUN:
    1. mem_halt: all en=0, pc_en=0. Next HALT, halt_out<=1.
    2. dmiss: all en=0, pc_en=0. Next DWAIT.
    3. hazard: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1. stall_cnt+1. If LDSTALL_CYC>1, next LDSTALL with ldcnt<=LDSTALL_CYC-1; else stay RUN.
    4. branch|jump: pc_en=1, ifid_flush=1, others en=1. flush_cnt+1. This applies regardless of ihit: the wrong-path fetch is discarded.
    5. !ihit: pc_en=0, ifid_flush=1, other latches en=1.
    6. Otherwise: all en=1, pc_en=1.
  - DWAIT:
    - While dmiss: all en=0, pc_en=0. Hold.
    - When dhit=1: apply RUN rules 3–6 this cycle. Next RUN, or LDSTALL if rule 3 fired with LDSTALL_CYC>1.
  - LDSTALL:
    - dmiss has priority: freeze all, ldcnt held, stay.
    - Otherwise apply the rule-3 outputs: stall_cnt+1, ldcnt-1, next RUN when ldcnt==1.
    - hazard/branch are ignored here; ID is frozen, so they re-evaluate in RUN.
- HALT: all en=0, pc_en=0, halt_out=1. Exit only via RST.
- Simultaneous events:
  - hazard with branch: hazard wins. The branch re-resolves after the bubble.
  - mem_halt with dmiss: halt wins.
  - Flush and enable asserted on the same latch: flush wins (latch clears).
- Counters saturate at all-ones and never wrap.
- RST mid-stall or mid-miss returns to RUN immediately; counters clear.

Decomposition:
- cpu_types_pkg gains pctrl_state_t (RUN=2'd0, DWAIT=2'd1, LDSTALL=2'd2, HALT=2'd3) and LDSTALL_MAX=15.
- Add a pipeline_ctrl_if interface following the existing pattern: modports ctrl and tb.
- One sub-module, sat_counter (param W; inc, clear, async RST), instantiated twice.

Test Plan:
1. Reset, then ihit=1 and no events → all en=1, pc_en=1, state_o=0, counters 0.
2. hazard=1 for 1 cycle, LDSTALL_CYC=3 → pc_en=0, ifid_en=0, idex_flush=1 for 3 cycles; state RUN→LDSTALL→RUN; stall_cnt=3.
3. mem_dREN=1, dhit=0 for 4 cycles, then dhit=1 → 4 cycles of all en=0 in DWAIT; all en=1 on the dhit cycle; next RUN.
4. branch=1 with ihit=0 → pc_en=1, ifid_flush=1; flush_cnt=1. hazard=1 with branch=1 → stall outputs, flush_cnt unchanged.
5. mem_halt=1 coincident with dmiss → halt_out=1 next edge, all en=0 forever. RST=1 → halt_out=0, state RUN.
6. Preload stall_cnt to all-ones via repeated hazards (CNT_W=4 build) → stays 4'hF.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline-controller state encoding and the latch-control bundle
// that the controller drives each cycle.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DWAIT   = 2'd1,
    LDSTALL = 2'd2,
    HALT    = 2'd3
  } pctrl_state_t;

  localparam int unsigned LDSTALL_MAX = 15;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } pctrl_ctl_t;

  localparam pctrl_ctl_t CtlFreeze = '{default: 1'b0};
  localparam pctrl_ctl_t CtlRun = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                    exmem_en: 1'b1, memwb_en: 1'b1, default: 1'b0};
  // Load-use bubble: hold PC and IF/ID, squash ID/EX, let the back end drain.
  localparam pctrl_ctl_t CtlStall = '{exmem_en: 1'b1, memwb_en: 1'b1, idex_flush: 1'b1,
                                      default: 1'b0};
  localparam pctrl_ctl_t CtlRedirect = '{pc_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
                                         memwb_en: 1'b1, ifid_flush: 1'b1, default: 1'b0};
  localparam pctrl_ctl_t CtlFetchWait = '{idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
                                          ifid_flush: 1'b1, default: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of pipeline-controller signals with a controller-side and a bench-side view.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
) (
  input logic CLK
);
  logic             RST;
  logic             hazard, branch, jump, ihit, dhit;
  logic             mem_dREN, mem_dWEN, mem_halt;
  logic             pc_en;
  logic             ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic             halt_out;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [1:0]       state_o;

  modport ctrl (
    input  CLK, RST, hazard, branch, jump, ihit, dhit, mem_dREN, mem_dWEN, mem_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halt_out, stall_cnt, flush_cnt, state_o
  );

  modport tb (
    input  CLK, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halt_out, stall_cnt, flush_cnt, state_o,
    output RST, hazard, branch, jump, ihit, dhit, mem_dREN, mem_dWEN, mem_halt
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline latch/PC sequencer: load-use bubbles, data-miss freeze, halt, perf counters.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned LDSTALL_CYC = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             hazard,
  input  logic             branch,
  input  logic             jump,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt_out,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_o
);

  localparam int unsigned LdW = $clog2(LDSTALL_MAX + 1);
  localparam logic [LdW-1:0] LdInit = LdW'(LDSTALL_CYC - 1);

  pctrl_state_t   state_q, state_d;
  logic [LdW-1:0] ldcnt_q, ldcnt_d;
  logic           halt_d;
  logic           dmiss, run_rules, stall_inc, flush_inc;
  pctrl_ctl_t     ctl, ctl_out;

  assign dmiss = (mem_dREN | mem_dWEN) & ~dhit;

  always_comb begin
    ctl       = CtlFreeze;
    state_d   = state_q;
    ldcnt_d   = ldcnt_q;
    halt_d    = halt_out;
    run_rules = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_halt) begin
          state_d = HALT;
          halt_d  = 1'b1;
        end else if (dmiss) begin
          state_d = DWAIT;
        end else begin
          run_rules = 1'b1;
        end
      end
      DWAIT: begin
        if (!dmiss) begin
          state_d   = RUN;
          run_rules = 1'b1;
        end
      end
      LDSTALL: begin
        // ID is frozen here, so hazard/branch are re-evaluated once back in RUN.
        if (!dmiss) begin
          ctl       = CtlStall;
          stall_inc = 1'b1;
          ldcnt_d   = ldcnt_q - LdW'(1);
          if (ldcnt_q == LdW'(1)) state_d = RUN;
        end
      end
      default: halt_d = 1'b1;
    endcase

    if (run_rules) begin
      if (hazard) begin
        ctl       = CtlStall;
        stall_inc = 1'b1;
        if (LDSTALL_CYC > 1) begin
          state_d = LDSTALL;
          ldcnt_d = LdInit;
        end
      end else if (branch | jump) begin
        ctl       = CtlRedirect;
        flush_inc = 1'b1;
      end else if (!ihit) begin
        ctl = CtlFetchWait;
      end else begin
        ctl = CtlRun;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= RUN;
      ldcnt_q  <= '0;
      halt_out <= 1'b0;
    end else begin
      state_q  <= state_d;
      ldcnt_q  <= ldcnt_d;
      halt_out <= halt_d;
    end
  end

  assign ctl_out     = RST ? CtlFreeze : ctl;
  assign pc_en       = ctl_out.pc_en;
  assign ifid_en     = ctl_out.ifid_en;
  assign idex_en     = ctl_out.idex_en;
  assign exmem_en    = ctl_out.exmem_en;
  assign memwb_en    = ctl_out.memwb_en;
  assign ifid_flush  = ctl_out.ifid_flush;
  assign idex_flush  = ctl_out.idex_flush;
  assign exmem_flush = ctl_out.exmem_flush;
  assign memwb_flush = ctl_out.memwb_flush;
  assign state_o     = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (stall_inc),
    .clear (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (flush_inc),
    .clear (1'b0),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (LDSTALL_CYC=3, 4-bit counters) with a per-cycle scoreboard.
module tb_pipeline_ctrl;

  localparam int unsigned CW = 4;

  // Control vector order: pc, ifid_en, idex_en, exmem_en, memwb_en, 4 flushes (ifid..memwb).
  localparam logic [8:0] E_RUN    = 9'b1_1111_0000;
  localparam logic [8:0] E_FREEZE = 9'b0_0000_0000;
  localparam logic [8:0] E_STALL  = 9'b0_0011_0100;
  localparam logic [8:0] E_REDIR  = 9'b1_0111_1000;
  localparam logic [8:0] E_FWAIT  = 9'b0_0111_1000;
  localparam logic [8:0] M_ALL    = 9'h1FF;
  localparam logic [8:0] M_NOIDEX = 9'b1_1011_1111;
  localparam logic [8:0] M_NOIFID = 9'b1_0111_1111;

  // Input vector order: hazard, branch, jump, ihit, dhit, dREN, dWEN, halt.
  localparam logic [7:0] I_IDLE   = 8'b0001_0000;
  localparam logic [7:0] I_HAZ    = 8'b1001_0000;
  localparam logic [7:0] I_DMISS  = 8'b0001_0100;

  typedef struct packed {
    logic [8:0] ctl;
    logic [8:0] mask;
    logic [1:0] st;
    logic [3:0] sc;
    logic [3:0] fc;
    logic       h;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CW)) bus (.CLK(clk));

  pipeline_ctrl #(.LDSTALL_CYC(3), .CNT_W(CW)) dut (
    .CLK         (bus.CLK),
    .RST         (bus.RST),
    .hazard      (bus.hazard),
    .branch      (bus.branch),
    .jump        (bus.jump),
    .ihit        (bus.ihit),
    .dhit        (bus.dhit),
    .mem_dREN    (bus.mem_dREN),
    .mem_dWEN    (bus.mem_dWEN),
    .mem_halt    (bus.mem_halt),
    .pc_en       (bus.pc_en),
    .ifid_en     (bus.ifid_en),
    .idex_en     (bus.idex_en),
    .exmem_en    (bus.exmem_en),
    .memwb_en    (bus.memwb_en),
    .ifid_flush  (bus.ifid_flush),
    .idex_flush  (bus.idex_flush),
    .exmem_flush (bus.exmem_flush),
    .memwb_flush (bus.memwb_flush),
    .halt_out    (bus.halt_out),
    .stall_cnt   (bus.stall_cnt),
    .flush_cnt   (bus.flush_cnt),
    .state_o     (bus.state_o)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  logic [8:0] ctl_obs;
  assign ctl_obs = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                    bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush};

  function automatic int sat(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // One cycle: drive at negedge, queue the expectation, compare away from the rising edge.
  task automatic step(input string tag, input logic rst, input logic [7:0] in,
                      input logic [8:0] ctl, input logic [8:0] mask, input logic [1:0] st,
                      input int sc, input int fc, input logic h);
    exp_t e;
    @(negedge clk);
    bus.RST = rst;
    {bus.hazard, bus.branch, bus.jump, bus.ihit, bus.dhit,
     bus.mem_dREN, bus.mem_dWEN, bus.mem_halt} = in;
    e.ctl  = ctl;
    e.mask = mask;
    e.st   = st;
    e.sc   = 4'(sc);
    e.fc   = 4'(fc);
    e.h    = h;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    chk({tag, ".ctl"}, 32'(ctl_obs & e.mask), 32'(e.ctl & e.mask));
    chk({tag, ".state"}, 32'(bus.state_o), 32'(e.st));
    chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(e.sc));
    chk({tag, ".flush_cnt"}, 32'(bus.flush_cnt), 32'(e.fc));
    chk({tag, ".halt"}, 32'(bus.halt_out), 32'(e.h));
  endtask

  initial begin
    bus.RST = 1'b1;
    {bus.hazard, bus.branch, bus.jump, bus.ihit, bus.dhit,
     bus.mem_dREN, bus.mem_dWEN, bus.mem_halt} = I_IDLE;

    step("rst_hold", 1, I_IDLE, E_FREEZE, M_ALL, 2'd0, 0, 0, 0);
    step("idle0", 0, I_IDLE, E_RUN, M_ALL, 2'd0, 0, 0, 0);
    step("idle1", 0, I_IDLE, E_RUN, M_ALL, 2'd0, 0, 0, 0);

    step("ld_haz", 0, I_HAZ, E_STALL, M_NOIDEX, 2'd0, 0, 0, 0);
    step("ld_st1", 0, I_IDLE, E_STALL, M_NOIDEX, 2'd2, 1, 0, 0);
    step("ld_st2", 0, I_IDLE, E_STALL, M_NOIDEX, 2'd2, 2, 0, 0);
    step("ld_done", 0, I_IDLE, E_RUN, M_ALL, 2'd0, 3, 0, 0);

    step("dm_run", 0, I_DMISS, E_FREEZE, M_ALL, 2'd0, 3, 0, 0);
    for (int i = 0; i < 3; i++) step("dm_wait", 0, I_DMISS, E_FREEZE, M_ALL, 2'd1, 3, 0, 0);
    step("dm_hit", 0, 8'b0001_1100, E_RUN, M_ALL, 2'd1, 3, 0, 0);
    step("dm_back", 0, I_IDLE, E_RUN, M_ALL, 2'd0, 3, 0, 0);

    step("br_noihit", 0, 8'b0100_0000, E_REDIR, M_NOIFID, 2'd0, 3, 0, 0);
    step("jmp", 0, 8'b0011_0000, E_REDIR, M_NOIFID, 2'd0, 3, 1, 0);
    step("fetch_wait", 0, 8'b0000_0000, E_FWAIT, M_NOIFID, 2'd0, 3, 2, 0);
    step("haz_br", 0, 8'b1101_0000, E_STALL, M_NOIDEX, 2'd0, 3, 2, 0);
    step("ld_br_ign", 0, 8'b0101_0000, E_STALL, M_NOIDEX, 2'd2, 4, 2, 0);
    step("ld_dmiss", 0, I_DMISS, E_FREEZE, M_ALL, 2'd2, 5, 2, 0);
    step("ld_resume", 0, I_IDLE, E_STALL, M_NOIDEX, 2'd2, 5, 2, 0);
    step("ld_exit", 0, I_IDLE, E_RUN, M_ALL, 2'd0, 6, 2, 0);

    step("dm2_run", 0, I_DMISS, E_FREEZE, M_ALL, 2'd0, 6, 2, 0);
    step("dm2_hit_haz", 0, 8'b1001_1100, E_STALL, M_NOIDEX, 2'd1, 6, 2, 0);
    step("dm2_st1", 0, I_IDLE, E_STALL, M_NOIDEX, 2'd2, 7, 2, 0);
    step("dm2_st2", 0, I_IDLE, E_STALL, M_NOIDEX, 2'd2, 8, 2, 0);

    for (int k = 0; k < 3; k++) begin
      step("sat_haz", 0, I_HAZ, E_STALL, M_NOIDEX, 2'd0, sat(9 + 3 * k), 2, 0);
      step("sat_st1", 0, I_IDLE, E_STALL, M_NOIDEX, 2'd2, sat(10 + 3 * k), 2, 0);
      step("sat_st2", 0, I_IDLE, E_STALL, M_NOIDEX, 2'd2, sat(11 + 3 * k), 2, 0);
    end
    step("sat_hold", 0, I_IDLE, E_RUN, M_ALL, 2'd0, 15, 2, 0);

    step("halt_dmiss", 0, 8'b0001_0101, E_FREEZE, M_ALL, 2'd0, 15, 2, 0);
    step("halted_idle", 0, I_IDLE, E_FREEZE, M_ALL, 2'd3, 15, 2, 1);
    step("halted_br", 0, 8'b0101_0000, E_FREEZE, M_ALL, 2'd3, 15, 2, 1);
    step("halted_haz", 0, I_HAZ, E_FREEZE, M_ALL, 2'd3, 15, 2, 1);
    step("halt_rst", 1, I_IDLE, E_FREEZE, M_ALL, 2'd0, 0, 0, 0);
    step("post_rst", 0, I_IDLE, E_RUN, M_ALL, 2'd0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
